// File: rtl/cap_sched.sv
// cap_sched: round-robin scheduler for three capture requesters sharing one
// capture/sync controller. It arbitrates, raises a trigger, waits for the
// controller's ready handshake, then reports completion. A sticky error flag
// records a handshake timeout.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_WAIT | resynchronising: waiting for capr_rdy=1 after reset/timeout
// S_IDLE | free; arbitrates among req when enable=1
// S_TRIG | cap_trig high, waiting for the controller to drop capr_rdy
// S_ACK  | one-cycle gap after the controller accepted the trigger
// S_DONE | waiting for capr_rdy=1 to signal capture complete
module cap_sched #(
  parameter int TMO_W = 20,
  parameter int CNT_W = 16
) (
  input  logic             clk50,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [2:0]       req,
  output logic [2:0]       gnt,
  output logic [2:0]       done,
  output logic             cap_trig,
  input  logic             capr_rdy,
  output logic             busy,
  output logic             tmo_err,
  output logic [CNT_W-1:0] cap_cnt
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_IDLE,
    S_TRIG,
    S_ACK,
    S_DONE
  } state_t;

  // The timeout fires on the edge where the counter would reach all-ones.
  localparam logic [TMO_W-1:0] TMO_FIRE = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state_q;
  logic [1:0]       last_q;
  logic [2:0]       gnt_q;
  logic [2:0]       done_q;
  logic             trig_q;
  logic             tmo_err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TMO_W-1:0] tmo_q;

  logic [1:0]       win_idx_d;
  logic             win_vld_d;
  logic [TMO_W-1:0] tmo_d;
  logic [CNT_W-1:0] cnt_d;

  // Round-robin pick: search starts at the bit after the last grant.
  always_comb begin
    win_vld_d = |req;
    win_idx_d = 2'd0;
    case (last_q)
      2'd0: begin
        if (req[1])      win_idx_d = 2'd1;
        else if (req[2]) win_idx_d = 2'd2;
        else             win_idx_d = 2'd0;
      end
      2'd1: begin
        if (req[2])      win_idx_d = 2'd2;
        else if (req[0]) win_idx_d = 2'd0;
        else             win_idx_d = 2'd1;
      end
      default: begin
        if (req[0])      win_idx_d = 2'd0;
        else if (req[1]) win_idx_d = 2'd1;
        else             win_idx_d = 2'd2;
      end
    endcase
  end

  // Saturating timeout increment and wrapping capture-count increment.
  always_comb begin
    tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
    cnt_d = cnt_q + CNT_W'(1);
  end

  // Main sequencer; every output except busy is a register set here.
  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state_q   <= S_WAIT;
      last_q    <= 2'd2;
      gnt_q     <= '0;
      done_q    <= '0;
      trig_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      cnt_q     <= '0;
      tmo_q     <= '0;
    end else begin
      done_q <= '0;
      tmo_q  <= '0;
      case (state_q)
        S_WAIT: begin
          if (capr_rdy) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (enable && win_vld_d) begin
            gnt_q   <= 3'b001 << win_idx_d;
            trig_q  <= 1'b1;
            last_q  <= win_idx_d;
            state_q <= S_TRIG;
          end
        end
        S_TRIG: begin
          if (!capr_rdy) begin
            trig_q  <= 1'b0;
            state_q <= S_ACK;
          end else if (tmo_q == TMO_FIRE) begin
            tmo_err_q <= 1'b1;
            gnt_q     <= '0;
            trig_q    <= 1'b0;
            state_q   <= S_WAIT;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        S_ACK: begin
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (capr_rdy) begin
            done_q  <= gnt_q;
            cnt_q   <= cnt_d;
            gnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (tmo_q == TMO_FIRE) begin
            tmo_err_q <= 1'b1;
            gnt_q     <= '0;
            trig_q    <= 1'b0;
            state_q   <= S_WAIT;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        default: begin
          gnt_q   <= '0;
          trig_q  <= 1'b0;
          state_q <= S_WAIT;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign cap_trig = trig_q;
  assign busy     = (state_q != S_IDLE);
  assign tmo_err  = tmo_err_q;
  assign cap_cnt  = cnt_q;

endmodule

// File: tb/tb_cap_sched.sv
// Directed bench for cap_sched. Instance a uses the default widths; instance b
// uses a 4-bit timeout and 2-bit capture counter for the timeout and wrap cases.
module tb_cap_sched;

  logic        clk50 = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  req;
  logic        rdy_a, rdy_b;

  logic [2:0]  gnt_a, done_a, gnt_b, done_b;
  logic        trig_a, busy_a, tmo_a, trig_b, busy_b, tmo_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int vecs = 0;
  int errs = 0;

  always #5 clk50 = ~clk50;

  cap_sched #(.TMO_W(20), .CNT_W(16)) dut_a (
    .clk50(clk50), .rst_n(rst_n), .enable(enable), .req(req),
    .gnt(gnt_a), .done(done_a), .cap_trig(trig_a), .capr_rdy(rdy_a),
    .busy(busy_a), .tmo_err(tmo_a), .cap_cnt(cnt_a)
  );

  cap_sched #(.TMO_W(4), .CNT_W(2)) dut_b (
    .clk50(clk50), .rst_n(rst_n), .enable(enable), .req(req),
    .gnt(gnt_b), .done(done_b), .cap_trig(trig_b), .capr_rdy(rdy_b),
    .busy(busy_b), .tmo_err(tmo_b), .cap_cnt(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk50);
      #1;
    end
  endtask

  // One full capture from S_IDLE with req already driven; ends in S_IDLE.
  task automatic serve(input bit sel, input logic [2:0] exp_g, input int exp_cnt,
                       input string tag);
    tick(1);
    chk({tag, " gnt"},  32'(sel ? gnt_b : gnt_a), 32'(exp_g));
    chk({tag, " trig"}, 32'(sel ? trig_b : trig_a), 32'd1);
    if (sel) rdy_b = 1'b0; else rdy_a = 1'b0;
    tick(2);
    if (sel) rdy_b = 1'b1; else rdy_a = 1'b1;
    tick(1);
    chk({tag, " done"}, 32'(sel ? done_b : done_a), 32'(exp_g));
    chk({tag, " cnt"},  sel ? 32'(cnt_b) : 32'(cnt_a), 32'(exp_cnt));
    chk({tag, " gnt_clr"}, 32'(sel ? gnt_b : gnt_a), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; req = 3'b000; rdy_a = 1'b0; rdy_b = 1'b0;
    tick(2);
    chk("rst gnt",  32'(gnt_a),  32'd0);
    chk("rst done", 32'(done_a), 32'd0);
    chk("rst trig", 32'(trig_a), 32'd0);
    chk("rst busy", 32'(busy_a), 32'd1);
    chk("rst tmo",  32'(tmo_a),  32'd0);
    chk("rst cnt",  32'(cnt_a),  32'd0);
    chk("rst busy_b", 32'(busy_b), 32'd1);
    chk("rst cnt_b",  32'(cnt_b),  32'd0);

    // Single request with a long capture
    rst_n = 1'b1; enable = 1'b1; rdy_a = 1'b1; req = 3'b001;
    tick(1);
    chk("sync idle", 32'(busy_a), 32'd0);
    chk("sync nognt", 32'(gnt_a), 32'd0);
    tick(1);
    chk("single gnt",  32'(gnt_a),  32'd1);
    chk("single trig", 32'(trig_a), 32'd1);
    chk("single busy", 32'(busy_a), 32'd1);
    rdy_a = 1'b0;
    tick(1);
    chk("trig fall", 32'(trig_a), 32'd0);
    chk("ack gnt",   32'(gnt_a),  32'd1);
    tick(19);
    chk("long gnt",  32'(gnt_a),  32'd1);
    chk("long done", 32'(done_a), 32'd0);
    chk("long cnt",  32'(cnt_a),  32'd0);
    chk("long tmo",  32'(tmo_a),  32'd0);
    rdy_a = 1'b1;
    tick(1);
    chk("single done", 32'(done_a), 32'd1);
    chk("single cnt",  32'(cnt_a),  32'd1);
    chk("single gclr", 32'(gnt_a),  32'd0);
    chk("single idle", 32'(busy_a), 32'd0);
    tick(1);
    chk("pulse end", 32'(done_a), 32'd0);
    chk("regrant",   32'(gnt_a),  32'd1);

    // Dropped request keeps the capture; a req seen while busy is not latched
    req = 3'b000; rdy_a = 1'b0;
    tick(1);
    chk("drop keep", 32'(gnt_a), 32'd1);
    req = 3'b100;
    tick(1);
    req = 3'b000; rdy_a = 1'b1;
    tick(1);
    chk("drop done", 32'(done_a), 32'd1);
    chk("drop cnt",  32'(cnt_a),  32'd2);
    tick(1);
    chk("nolatch gnt",  32'(gnt_a),  32'd0);
    chk("nolatch busy", 32'(busy_a), 32'd0);

    // Round robin from reset with all requesters active
    rst_n = 1'b0;
    tick(1);
    chk("rr rst cnt", 32'(cnt_a), 32'd0);
    rst_n = 1'b1; req = 3'b111;
    tick(1);
    serve(1'b0, 3'b001, 1, "rr1");
    serve(1'b0, 3'b010, 2, "rr2");
    serve(1'b0, 3'b100, 3, "rr3");
    serve(1'b0, 3'b001, 4, "rr4");

    // Enable gating: drop enable while 001 is in S_DONE
    req = 3'b011;
    serve(1'b0, 3'b010, 5, "en pre");
    tick(1);
    chk("en gnt", 32'(gnt_a), 32'd1);
    rdy_a = 1'b0;
    tick(2);
    enable = 1'b0;
    tick(1);
    chk("en hold", 32'(gnt_a), 32'd1);
    rdy_a = 1'b1;
    tick(1);
    chk("en done", 32'(done_a), 32'd1);
    chk("en cnt",  32'(cnt_a),  32'd6);
    tick(3);
    chk("en block gnt",  32'(gnt_a),  32'd0);
    chk("en block busy", 32'(busy_a), 32'd0);
    enable = 1'b1;
    serve(1'b0, 3'b010, 7, "en resume");

    // Reset while in S_DONE
    req = 3'b001;
    tick(1);
    chk("mr gnt", 32'(gnt_a), 32'd1);
    rdy_a = 1'b0;
    tick(2);
    rst_n = 1'b0; rdy_a = 1'b1;
    tick(1);
    chk("mr done", 32'(done_a), 32'd0);
    chk("mr cnt",  32'(cnt_a),  32'd0);
    chk("mr busy", 32'(busy_a), 32'd1);
    chk("mr gnt0", 32'(gnt_a),  32'd0);
    chk("mr trig", 32'(trig_a), 32'd0);
    rst_n = 1'b1; req = 3'b000;
    tick(1);
    chk("mr idle", 32'(busy_a), 32'd0);
    chk("mr done2", 32'(done_a), 32'd0);

    // Timeout on instance b: capr_rdy stuck high after the trigger
    rdy_a = 1'b0; rdy_b = 1'b1; req = 3'b001;
    tick(1);
    chk("to idle", 32'(busy_b), 32'd0);
    tick(1);
    chk("to gnt",  32'(gnt_b),  32'd1);
    chk("to trig", 32'(trig_b), 32'd1);
    req = 3'b000;
    tick(14);
    chk("to early err",  32'(tmo_b),  32'd0);
    chk("to early gnt",  32'(gnt_b),  32'd1);
    chk("to early trig", 32'(trig_b), 32'd1);
    tick(1);
    chk("to err",  32'(tmo_b),  32'd1);
    chk("to gnt0", 32'(gnt_b),  32'd0);
    chk("to trig0", 32'(trig_b), 32'd0);
    chk("to done", 32'(done_b), 32'd0);
    chk("to cnt",  32'(cnt_b),  32'd0);
    chk("to busy", 32'(busy_b), 32'd1);
    rdy_b = 1'b0;
    tick(1);
    chk("to wait busy", 32'(busy_b), 32'd1);
    chk("to wait done", 32'(done_b), 32'd0);
    rdy_b = 1'b1;
    tick(1);
    chk("to resync", 32'(busy_b), 32'd0);
    chk("to sticky", 32'(tmo_b),  32'd1);
    req = 3'b010;
    serve(1'b1, 3'b010, 1, "to next");

    // Counter wrap on instance b (2-bit counter)
    req = 3'b001; rst_n = 1'b0;
    tick(1);
    chk("wrap rst err", 32'(tmo_b), 32'd0);
    chk("wrap rst cnt", 32'(cnt_b), 32'd0);
    rst_n = 1'b1;
    tick(1);
    serve(1'b1, 3'b001, 1, "wrap1");
    serve(1'b1, 3'b001, 2, "wrap2");
    serve(1'b1, 3'b001, 3, "wrap3");
    serve(1'b1, 3'b001, 0, "wrap4");
    serve(1'b1, 3'b001, 1, "wrap5");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
